// File: rtl/ifetch_buffer.sv
// Fetch stage between the PC register and instruction memory: issues word fetches,
// tracks in-flight PCs, buffers returned instructions for decode, and drops work on redirect.
module ifetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            srst_n,
  input  logic [XLEN-1:0] pc,
  output logic            stall_f,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_ins_data [DEPTH];
  logic [XLEN-1:0] r_ins_pc   [DEPTH];
  logic [XLEN-1:0] r_tag      [DEPTH];
  logic [PW-1:0]   r_ins_wr, r_ins_rd, r_tag_wr, r_tag_rd;
  logic [CW-1:0]   r_count, r_outstanding, r_discard;

  logic [CW:0]     w_inuse;
  logic            w_credit, w_accept, w_rsp, w_drop, w_push, w_pop;

  // Credit covers buffered plus in-flight entries, so a response always has a slot.
  assign w_inuse  = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit = (w_inuse < L_DEPTH);

  assign imem_req_valid = srst_n & w_credit & ~flush;
  assign imem_req_addr  = pc;
  assign w_accept       = imem_req_valid & imem_req_ready;
  assign stall_f        = ~(srst_n & (w_accept | flush));

  assign w_rsp  = imem_rsp_valid & (r_outstanding != '0);
  assign w_drop = w_rsp & ((r_discard != '0) | flush);
  assign w_push = w_rsp & ~w_drop;
  assign w_pop  = (r_count != '0) & dec_ready & ~flush;

  assign dec_valid = (r_count != '0);
  assign dec_instr = r_ins_data[r_ins_rd];
  assign dec_pc    = r_ins_pc[r_ins_rd];

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_ins_wr      <= '0;
      r_ins_rd      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ins_data[i] <= '0;
        r_ins_pc[i]   <= '0;
        r_tag[i]      <= '0;
      end
    end else begin
      if (w_accept) begin
        r_tag[r_tag_wr] <= pc;
        r_tag_wr        <= r_tag_wr + PW'(1);
      end
      if (w_rsp) begin
        r_tag_rd <= r_tag_rd + PW'(1);
      end

      case ({w_accept, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      // Everything still in flight after this edge belongs to the old path.
      if (flush) begin
        r_discard <= r_outstanding - CW'(w_rsp);
      end else if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end

      if (w_push) begin
        r_ins_data[r_ins_wr] <= imem_rsp_data;
        r_ins_pc[r_ins_wr]   <= r_tag[r_tag_rd];
        r_ins_wr             <= r_ins_wr + PW'(1);
      end

      if (flush) begin
        r_ins_wr <= '0;
        r_ins_rd <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop) begin
          r_ins_rd <= r_ins_rd + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: directed scenarios plus a randomized run,
// all compared against a queue-based reference model and an in-bench memory.
module tb_ifetch_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            srst_n, flush, imem_req_ready, imem_rsp_valid, dec_ready;
  logic [XLEN-1:0] pc, imem_rsp_data;
  logic            stall_f, imem_req_valid, dec_valid;
  logic [XLEN-1:0] imem_req_addr, dec_instr, dec_pc;

  always #5 clk = ~clk;

  ifetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst_n(srst_n), .pc(pc), .stall_f(stall_f), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  logic [31:0] tb_pc, tb_pc_next;
  logic [31:0] m_inf_pc[$];
  bit          m_doomed[$];
  int          m_due[$];
  logic [31:0] m_buf_instr[$];
  logic [31:0] m_buf_pc[$];
  bit          m_zero_head;
  int          lat_min = 1, lat_max = 1, rsp_pct = 100;
  bit          spur_en = 1'b0;

  bit          exp_req_valid, exp_stall, exp_dec_valid, exp_head_chk;
  logic [31:0] exp_addr, exp_dec_instr, exp_dec_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive inputs at negedge, snapshot model expectations, advance model.
  task automatic cyc(input bit rst_i, input bit fl_i, input bit rdy_i, input bit drdy_i,
                     input logic [31:0] tgt);
    bit          acc, rsp, popd, dm;
    logic [31:0] p;
    @(negedge clk);
    cyc_n++;
    tb_pc          = tb_pc_next;
    pc             = tb_pc;
    srst_n         = rst_i;
    flush          = fl_i;
    imem_req_ready = rdy_i;
    dec_ready      = drdy_i;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_i) begin
      if (m_inf_pc.size() > 0) begin
        if (cyc_n >= m_due[0] && $urandom_range(0, 99) < rsp_pct) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(m_inf_pc[0]);
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
      end
    end
    exp_req_valid = rst_i && (m_buf_pc.size() + m_inf_pc.size() < DEPTH) && !fl_i;
    exp_addr      = tb_pc;
    acc           = exp_req_valid && rdy_i;
    exp_stall     = !(rst_i && (acc || fl_i));
    exp_dec_valid = (m_buf_pc.size() != 0);
    exp_head_chk  = exp_dec_valid || m_zero_head;
    exp_dec_instr = exp_dec_valid ? m_buf_instr[0] : 32'h0;
    exp_dec_pc    = exp_dec_valid ? m_buf_pc[0] : 32'h0;
    #1;
    tb_pc_next = exp_stall ? tb_pc : (fl_i ? tgt : tb_pc + 32'd4);
    if (!rst_i) begin
      m_inf_pc.delete(); m_doomed.delete(); m_due.delete();
      m_buf_instr.delete(); m_buf_pc.delete();
      m_zero_head = 1'b1;
    end else begin
      rsp  = imem_rsp_valid && (m_inf_pc.size() > 0);
      popd = exp_dec_valid && drdy_i && !fl_i;
      if (popd) begin
        void'(m_buf_instr.pop_front());
        void'(m_buf_pc.pop_front());
      end
      if (rsp) begin
        p  = m_inf_pc.pop_front();
        dm = m_doomed.pop_front();
        void'(m_due.pop_front());
        if (!(dm || fl_i)) begin
          m_buf_instr.push_back(imem_rsp_data);
          m_buf_pc.push_back(p);
          m_zero_head = 1'b0;
        end
      end
      if (fl_i) begin
        m_buf_instr.delete();
        m_buf_pc.delete();
        foreach (m_doomed[i]) m_doomed[i] = 1'b1;
      end
      if (acc) begin
        m_inf_pc.push_back(tb_pc);
        m_doomed.push_back(1'b0);
        m_due.push_back(cyc_n + int'($urandom_range(lat_min, lat_max)));
      end
    end
  endtask

  task automatic drain();
    int k;
    rsp_pct = 100; lat_min = 1; lat_max = 1; spur_en = 1'b0;
    k = 0;
    while ((m_inf_pc.size() > 0 || m_buf_pc.size() > 0) && k < 50) begin
      cyc(1, 0, 0, 1, 32'h0);
      k++;
    end
    cyc(1, 0, 0, 1, 32'h0);
    n_checks++;
    if (k >= 50 || dec_valid !== 1'b0) $display("FAIL drain_timeout: dec_valid=%b cycles=%0d required idle", dec_valid, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    tb_pc_next = 32'h0;
    cyc(0, 0, 1, 1, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_checks++; if (stall_f !== 1'b1) $display("FAIL rst_stall: got %b want 1", stall_f); else n_pass++;
    cyc(0, 1, 1, 1, 32'h80);
    n_checks++; if (stall_f !== 1'b1) $display("FAIL rst_flush_stall: got %b want 1", stall_f); else n_pass++;
    cyc(1, 0, 0, 1, 32'h0);
    n_checks++; if (dec_valid !== 1'b0) $display("FAIL rst_dec_valid: got %b want 0", dec_valid); else n_pass++;
    n_checks++; if (dec_pc !== 32'h0) $display("FAIL rst_dec_pc: got %h want 0", dec_pc); else n_pass++;
    n_checks++; if (dec_instr !== 32'h0) $display("FAIL rst_dec_instr: got %h want 0", dec_instr); else n_pass++;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 1, 1, 32'h0);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(k*4))
        $display("FAIL stream_req: k=%0d got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, 32'(k*4)); else n_pass++;
      n_checks++; if (stall_f !== 1'b0) $display("FAIL stream_stall: k=%0d got %b want 0", k, stall_f); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'((k-2)*4) || dec_instr !== instr_of(32'((k-2)*4)))
          $display("FAIL stream_dec: k=%0d got v=%b pc=%h i=%h want pc=%h", k, dec_valid, dec_pc, dec_instr, 32'((k-2)*4)); else n_pass++;
      end else begin
        n_checks++; if (dec_valid !== 1'b0) $display("FAIL stream_early_dec: k=%0d got %b want 0", k, dec_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    drain();
    tb_pc_next = 32'h0;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 1, 0, 32'h0);
      if (k < 4) begin
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(k*4) || stall_f !== 1'b0)
          $display("FAIL bp_req: k=%0d got v=%b a=%h s=%b want v=1 a=%h s=0", k, imem_req_valid, imem_req_addr, stall_f, 32'(k*4)); else n_pass++;
      end else begin
        n_checks++; if (imem_req_valid !== 1'b0 || stall_f !== 1'b1)
          $display("FAIL bp_full: k=%0d got v=%b s=%b want v=0 s=1", k, imem_req_valid, stall_f); else n_pass++;
      end
      if (k >= 2) begin
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0)
          $display("FAIL bp_hold: k=%0d got v=%b pc=%h want v=1 pc=0", k, dec_valid, dec_pc); else n_pass++;
      end
    end
    cyc(1, 0, 1, 1, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b0 || dec_pc !== 32'h0)
      $display("FAIL bp_pop_no_credit: got v=%b pc=%h want v=0 pc=0", imem_req_valid, dec_pc); else n_pass++;
    cyc(1, 0, 1, 1, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10 || stall_f !== 1'b0 || dec_pc !== 32'h4)
      $display("FAIL bp_resume: got v=%b a=%h s=%b pc=%h want v=1 a=10 s=0 pc=4", imem_req_valid, imem_req_addr, stall_f, dec_pc); else n_pass++;
  endtask

  task automatic test_req_stall();
    drain();
    tb_pc_next = 32'h20;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 1, 32'h0);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20 || stall_f !== 1'b1)
        $display("FAIL rs_wait: k=%0d got v=%b a=%h s=%b want v=1 a=20 s=1", k, imem_req_valid, imem_req_addr, stall_f); else n_pass++;
    end
    cyc(1, 0, 1, 1, 32'h0);
    n_checks++; if (stall_f !== 1'b0 || imem_req_addr !== 32'h20) $display("FAIL rs_accept: got s=%b a=%h want s=0 a=20", stall_f, imem_req_addr); else n_pass++;
    cyc(1, 0, 0, 1, 32'h0);
    n_checks++; if (imem_req_addr !== 32'h24 || stall_f !== 1'b1 || dec_valid !== 1'b0)
      $display("FAIL rs_after: got a=%h s=%b dv=%b want a=24 s=1 dv=0", imem_req_addr, stall_f, dec_valid); else n_pass++;
    cyc(1, 0, 0, 1, 32'h0);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h20 || dec_instr !== instr_of(32'h20))
      $display("FAIL rs_dec: got v=%b pc=%h i=%h want pc=20", dec_valid, dec_pc, dec_instr); else n_pass++;
    cyc(1, 0, 0, 1, 32'h0);
    n_checks++; if (dec_valid !== 1'b0) $display("FAIL rs_single: got dv=%b want 0", dec_valid); else n_pass++;
  endtask

  task automatic test_flush();
    int k;
    drain();
    tb_pc_next = 32'h40;
    lat_min = 3; lat_max = 3;
    cyc(1, 0, 1, 1, 32'h0);
    cyc(1, 0, 1, 1, 32'h0);
    lat_min = 1; lat_max = 1;
    cyc(1, 1, 1, 1, 32'h100);
    n_checks++; if (stall_f !== 1'b0 || imem_req_valid !== 1'b0)
      $display("FAIL fl_cycle: got s=%b v=%b want s=0 v=0", stall_f, imem_req_valid); else n_pass++;
    k = 0;
    do begin
      cyc(1, 0, 1, 0, 32'h0);
      k++;
    end while (dec_valid !== 1'b1 && k < 12);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== instr_of(32'h100))
      $display("FAIL fl_first_dec: got v=%b pc=%h i=%h want pc=100 after %0d cycles", dec_valid, dec_pc, dec_instr, k); else n_pass++;
  endtask

  task automatic test_flush_rsp();
    drain();
    tb_pc_next = 32'h200;
    lat_min = 2; lat_max = 2;
    cyc(1, 0, 1, 1, 32'h0);
    lat_min = 1; lat_max = 1;
    cyc(1, 0, 0, 1, 32'h0);
    cyc(1, 1, 0, 1, 32'h300);
    n_checks++; if (stall_f !== 1'b0 || imem_rsp_valid !== 1'b1)
      $display("FAIL fr_cycle: got s=%b rsp=%b want s=0 rsp=1", stall_f, imem_rsp_valid); else n_pass++;
    cyc(1, 0, 1, 1, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || stall_f !== 1'b0 || dec_valid !== 1'b0)
      $display("FAIL fr_req: got v=%b a=%h s=%b dv=%b want v=1 a=300 s=0 dv=0", imem_req_valid, imem_req_addr, stall_f, dec_valid); else n_pass++;
    cyc(1, 0, 0, 1, 32'h0);
    cyc(1, 0, 0, 1, 32'h0);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h300 || dec_instr !== instr_of(32'h300))
      $display("FAIL fr_dec: got v=%b pc=%h i=%h want pc=300", dec_valid, dec_pc, dec_instr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drain();
    tb_pc_next = 32'h500;
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h500 || m_buf_pc.size() != 3)
      $display("FAIL rm_buffered: got v=%b pc=%h want v=1 pc=500 (3 buffered)", dec_valid, dec_pc); else n_pass++;
    cyc(0, 0, 1, 0, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b0 || stall_f !== 1'b1)
      $display("FAIL rm_rst: got v=%b s=%b want v=0 s=1", imem_req_valid, stall_f); else n_pass++;
    cyc(1, 0, 1, 1, 32'h0);
    n_checks++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== 32'h0)
      $display("FAIL rm_cleared: got v=%b pc=%h i=%h want 0/0/0", dec_valid, dec_pc, dec_instr); else n_pass++;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h50C)
      $display("FAIL rm_restart: got v=%b a=%h want v=1 a=50c", imem_req_valid, imem_req_addr); else n_pass++;
  endtask

  task automatic test_random();
    bit r, f, rd, dr;
    drain();
    lat_min = 1; lat_max = 4; rsp_pct = 80; spur_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) != 0);
      f  = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 6);
      cyc(r, f, rd, dr, $urandom & 32'hFFFF_FFFC);
      n_checks++; if (imem_req_valid !== exp_req_valid)
        $display("FAIL rnd_req_valid: k=%0d got %b want %b", k, imem_req_valid, exp_req_valid); else n_pass++;
      n_checks++; if (stall_f !== exp_stall)
        $display("FAIL rnd_stall: k=%0d got %b want %b", k, stall_f, exp_stall); else n_pass++;
      n_checks++; if (dec_valid !== exp_dec_valid)
        $display("FAIL rnd_dec_valid: k=%0d got %b want %b", k, dec_valid, exp_dec_valid); else n_pass++;
      if (exp_req_valid) begin
        n_checks++; if (imem_req_addr !== exp_addr)
          $display("FAIL rnd_addr: k=%0d got %h want %h", k, imem_req_addr, exp_addr); else n_pass++;
      end
      if (exp_head_chk) begin
        n_checks++; if (dec_pc !== exp_dec_pc || dec_instr !== exp_dec_instr)
          $display("FAIL rnd_head: k=%0d got pc=%h i=%h want pc=%h i=%h", k, dec_pc, dec_instr, exp_dec_pc, exp_dec_instr); else n_pass++;
      end
    end
  endtask

  initial begin
    srst_n = 1'b0; flush = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; pc = '0;
    tb_pc = '0; tb_pc_next = '0; m_zero_head = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_flush();
    test_flush_rsp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Fetch-stage consumer of the program counter; sits between the PC register and instruction memory.
- Issues word fetches at the current PC over a valid/ready request channel and accepts in-order responses of variable latency.
- Buffers fetched instructions with their PCs for decode and drives stall_f back to the PC register, so the PC advances only when a fetch is accepted.
- On flush (branch/jump redirect), discards buffered and in-flight instructions.

Parameters:
- XLEN, 32, address/instruction width
- DEPTH, 4, instruction FIFO entries and maximum requests in flight (power of 2, ≥2)

Ports:
- clk  in  1  clock
- srst_n  in  1  synchronous reset, active-low; sampled on posedge clk
- pc  in  XLEN  current PC from the PC register
- stall_f  out  1  1 = PC register holds; 0 = PC register loads its next value
- flush  in  1  redirect; discard all fetched and in-flight instructions
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; responses return in request order
- imem_rsp_data  in  XLEN  fetched instruction
- dec_valid  out  1  instruction available to decode
- dec_instr  out  XLEN  head instruction
- dec_pc  out  XLEN  PC of head instruction
- dec_ready  in  1  decode consumes head

Behaviour:
- Reset (srst_n=0 at posedge):
  - FIFO count, outstanding, discard, and tag FIFO all cleared.
  - Outputs next cycle: dec_valid=0, dec_instr=0, dec_pc=0.
- While srst_n=0: imem_req_valid=0 and stall_f=1 (combinational on srst_n).
- Credit: credit = (fifo_count + outstanding < DEPTH), using registered values only; a same-cycle pop grants no credit.
- Request issue: imem_req_valid = srst_n & credit & !flush; imem_req_addr = pc.
- Accept: accept = imem_req_valid & imem_req_ready. Push pc into the tag FIFO; outstanding += 1.
- stall_f = !(accept | flush):
  - PC advances exactly once per accepted fetch.
  - PC always loads on flush so the redirect target is taken.
- Response (imem_rsp_valid=1 and outstanding>0):
  - Pop the tag FIFO; outstanding -= 1.
  - If discard>0 or flush=1: drop the response; discard -= 1 if discard>0.
  - Otherwise: push {data, tag} into the instruction FIFO.
- Responses arriving with outstanding=0 are ignored (no state change).
- Accept and response in the same cycle: outstanding unchanged; tag FIFO pushes and pops.
- Flush at posedge:
  - Instruction FIFO emptied; dec_valid=0 next cycle.
  - discard <= outstanding minus any response dropped that same cycle.
  - No request is issued in the flush cycle.
- Decode interface:
  - dec_valid = fifo_count != 0; dec_instr/dec_pc show the head entry (registered storage).
  - Pop when dec_valid & dec_ready & !flush.
  - Head holds stable while dec_ready=0.
- Latency: a response in cycle N is visible on dec_valid in cycle N+1. Minimum request-to-decode latency is 2 cycles with 1-cycle memory.
- Push and pop in the same cycle: count unchanged. Overflow is impossible by credit; underflow is impossible by gating.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards everything. Memory shares the reset, so no stale responses follow.

Test Plan:
- Reset, then 1-cycle memory with ready=1 and dec_ready=1, pc stepping 0x0,0x4,0x8 → requests at 0x0,0x4,0x8 on consecutive cycles; dec_pc 0x0,0x4,0x8 with matching instr; stall_f=0 every cycle after reset.
- dec_ready=0, memory always responds → exactly 4 requests accepted (0x0–0xC); then imem_req_valid=0 and stall_f=1; dec_pc holds 0x0; raising dec_ready resumes fetch at 0x10.
- imem_req_ready=0 for 3 cycles at pc=0x20 → stall_f=1, imem_req_addr stays 0x20, outstanding stays 0; on ready=1 a single request issues.
- 2 requests in flight (0x40,0x44), flush with redirect pc=0x100 → stall_f=0 in the flush cycle; both responses dropped; first dec_pc after flush is 0x100.
- Response and flush in the same cycle with 1 outstanding → response dropped; discard=0; next request accepted and delivered normally.
- srst_n=0 for 1 cycle with 3 entries buffered → dec_valid=0, dec_pc=0, imem_req_valid=0 next cycle; fetch restarts from the pc presented.
